// File: rtl/reg_file_2r1w_if.sv
// Bus bundle for the 2-read/1-write register file: one write port and
// two read ports. The master drives addresses, enables and write data.
// The slave returns the read data.
interface reg_file_2r1w_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32
);
  localparam int AW = $clog2(DEPTH);

  logic             we;
  logic [AW-1:0]    waddr;
  logic [WIDTH-1:0] wdata;
  logic             re1;
  logic [AW-1:0]    raddr1;
  logic [WIDTH-1:0] rdata1;
  logic             re2;
  logic [AW-1:0]    raddr2;
  logic [WIDTH-1:0] rdata2;

  modport master (
    output we, waddr, wdata, re1, raddr1, re2, raddr2,
    input  rdata1, rdata2
  );

  modport slave (
    input  we, waddr, wdata, re1, raddr1, re2, raddr2,
    output rdata1, rdata2
  );
endinterface

// File: rtl/reg_file_2r1w.sv
// Register file with two read ports and one write port.
// Register 0 can be hardwired to zero. Same-cycle write data can be
// forwarded to a read port that addresses the register being written.
// Read data can be combinational or registered behind a read enable.
// The reset input is an asynchronous clear of every word and every
// output register.
module reg_file_2r1w #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1,
  parameter bit OUT_REG  = 1'b0
) (
  input  logic           clk,
  input  logic           reset,
  reg_file_2r1w_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] v1;
  logic [WIDTH-1:0] v2;

  // Read priority: reset, then the zero register, then bypass, then storage.
  // Reset forces zero so that a forwarded wdata cannot leak out of a
  // combinational port while the file is being cleared.
  function automatic logic [WIDTH-1:0] read_word(
    input logic             rst,
    input logic [AW-1:0]    ra,
    input logic             w_en,
    input logic [AW-1:0]    wa,
    input logic [WIDTH-1:0] wd,
    input logic [WIDTH-1:0] stored
  );
    if (rst)
      return '0;
    else if (ZERO_REG && (ra == '0))
      return '0;
    else if (BYPASS && w_en && (ra == wa))
      return wd;
    else
      return stored;
  endfunction

  // Storage: async clear, and a write that is dropped for register 0 when it is hardwired.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (bus.we && !(ZERO_REG && (bus.waddr == '0))) begin
      mem[bus.waddr] <= bus.wdata;
    end
  end

  // Read value selected for port 1.
  always_comb begin
    v1 = '0;
    v1 = read_word(reset, bus.raddr1, bus.we, bus.waddr, bus.wdata, mem[bus.raddr1]);
  end

  // Read value selected for port 2.
  always_comb begin
    v2 = '0;
    v2 = read_word(reset, bus.raddr2, bus.we, bus.waddr, bus.wdata, mem[bus.raddr2]);
  end

  generate
    if (OUT_REG) begin : g_out_reg
      logic [WIDTH-1:0] rdata1_q;
      logic [WIDTH-1:0] rdata2_q;

      // Output registers capture the selected value when their read enable is high.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          rdata1_q <= '0;
          rdata2_q <= '0;
        end else begin
          if (bus.re1) rdata1_q <= v1;
          if (bus.re2) rdata2_q <= v2;
        end
      end

      assign bus.rdata1 = rdata1_q;
      assign bus.rdata2 = rdata2_q;
    end else begin : g_out_comb
      // The read enables have no effect on the combinational ports.
      logic unused_re;
      assign unused_re  = bus.re1 ^ bus.re2;
      assign bus.rdata1 = v1;
      assign bus.rdata2 = v2;
    end
  endgenerate
endmodule

// File: tb/tb_reg_file_2r1w.sv
// Directed bench for reg_file_2r1w. It uses three configurations:
//   d0: default parameters (32x32, zero register, bypass, combinational reads)
//   d1: 32x32 without a zero register and without bypass
//   d2: 8x8 with a zero register, bypass and registered reads
module tb_reg_file_2r1w;
  logic clk;
  logic reset;
  int   n_chk;
  int   n_pass;

  reg_file_2r1w_if #(.WIDTH(32), .DEPTH(32)) b0 ();
  reg_file_2r1w_if #(.WIDTH(32), .DEPTH(32)) b1 ();
  reg_file_2r1w_if #(.WIDTH(8),  .DEPTH(8))  b2 ();

  reg_file_2r1w d0 (.clk(clk), .reset(reset), .bus(b0));

  reg_file_2r1w #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1'b0), .BYPASS(1'b0), .OUT_REG(1'b0))
    d1 (.clk(clk), .reset(reset), .bus(b1));

  reg_file_2r1w #(.WIDTH(8), .DEPTH(8), .ZERO_REG(1'b1), .BYPASS(1'b1), .OUT_REG(1'b1))
    d2 (.clk(clk), .reset(reset), .bus(b2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    else
      n_pass++;
  endtask

  // Write the same word into d0 and d1. The write lands at the next rising edge.
  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    b0.we = 1'b1; b0.waddr = a; b0.wdata = d;
    b1.we = 1'b1; b1.waddr = a; b1.wdata = d;
    @(posedge clk); #1;
    b0.we = 1'b0;
    b1.we = 1'b0;
  endtask

  task automatic wr8(input logic [2:0] a, input logic [7:0] d);
    b2.we = 1'b1; b2.waddr = a; b2.wdata = d;
    @(posedge clk); #1;
    b2.we = 1'b0;
  endtask

  initial begin
    logic [31:0] e1;
    logic [31:0] e2;
    n_chk  = 0;
    n_pass = 0;
    reset  = 1'b1;
    b0.we = 1'b0; b0.waddr = '0; b0.wdata = '0; b0.re1 = 1'b0; b0.raddr1 = '0; b0.re2 = 1'b0; b0.raddr2 = '0;
    b1.we = 1'b0; b1.waddr = '0; b1.wdata = '0; b1.re1 = 1'b0; b1.raddr1 = '0; b1.re2 = 1'b0; b1.raddr2 = '0;
    b2.we = 1'b0; b2.waddr = '0; b2.wdata = '0; b2.re1 = 1'b0; b2.raddr1 = '0; b2.re2 = 1'b0; b2.raddr2 = '0;
    #2;
    chk("por_rd1", b0.rdata1, 32'h0);
    chk("por_rd2_reg", {24'h0, b2.rdata2}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;

    // Load registers 1..31, then apply reset in the middle of a cycle.
    for (int i = 1; i < 32; i++) wr(5'(i), 32'hA5A5_0000 + 32'(i));
    b0.raddr1 = 5'd5; b0.raddr2 = 5'd9;
    #1;
    chk("pre_rst_rd1", b0.rdata1, 32'hA5A5_0005);
    chk("pre_rst_rd2", b0.rdata2, 32'hA5A5_0009);
    #1;
    reset = 1'b1;
    #1;
    chk("rst_async_rd1", b0.rdata1, 32'h0);
    chk("rst_async_rd2", b0.rdata2, 32'h0);
    // A write held active during reset must be lost.
    b1.we = 1'b1; b1.waddr = 5'd3; b1.wdata = 32'h1234_5678;
    @(posedge clk); #1;
    b1.we = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 32; i++) begin
      b0.raddr1 = 5'(i); b0.raddr2 = 5'(31 - i);
      b1.raddr1 = 5'(i);
      #1;
      chk($sformatf("rst_clear_d0_%0d", i), b0.rdata1 | b0.rdata2, 32'h0);
      chk($sformatf("rst_clear_d1_%0d", i), b1.rdata1, 32'h0);
    end

    // Sweep writes and reads on both ports, with opposite address orders.
    @(posedge clk); #1;
    for (int i = 1; i < 32; i++) wr(5'(i), 32'hA5A5_0000 + 32'(i));
    for (int i = 0; i < 32; i++) begin
      b0.raddr1 = 5'(i); b0.raddr2 = 5'(31 - i);
      #1;
      e1 = (i == 0)  ? 32'h0 : 32'hA5A5_0000 + 32'(i);
      e2 = (i == 31) ? 32'h0 : 32'hA5A5_0000 + 32'(31 - i);
      chk($sformatf("sweep_rd1_%0d", i), b0.rdata1, e1);
      chk($sformatf("sweep_rd2_%0d", i), b0.rdata2, e2);
    end

    // Zero register: the write to address 0 is dropped only when register 0 is hardwired.
    wr(5'd0, 32'hFFFF_FFFF);
    b0.raddr1 = 5'd0; b0.raddr2 = 5'd0; b1.raddr1 = 5'd0;
    #1;
    chk("zero_d0_rd1", b0.rdata1, 32'h0);
    chk("zero_d0_rd2", b0.rdata2, 32'h0);
    chk("zero_d1_rd1", b1.rdata1, 32'hFFFF_FFFF);
    // A write to 0 with bypass active must still read as 0.
    b0.we = 1'b1; b0.waddr = 5'd0; b0.wdata = 32'h5555_5555;
    #1;
    chk("zero_over_bypass", b0.rdata1, 32'h0);
    b0.we = 1'b0;
    @(posedge clk); #1;

    // Bypass: d0 forwards the new data, while d1 shows the old data until the edge.
    wr(5'd5, 32'h1111_1111);
    b0.raddr1 = 5'd5; b1.raddr1 = 5'd5;
    b0.we = 1'b1; b0.waddr = 5'd5; b0.wdata = 32'h2222_2222;
    b1.we = 1'b1; b1.waddr = 5'd5; b1.wdata = 32'h2222_2222;
    #1;
    chk("bypass_d0", b0.rdata1, 32'h2222_2222);
    chk("nobypass_old_d1", b1.rdata1, 32'h1111_1111);
    @(posedge clk); #1;
    b0.we = 1'b0; b1.we = 1'b0;
    chk("nobypass_new_d1", b1.rdata1, 32'h2222_2222);

    // Both ports addressing the same register, with and without a write in flight.
    wr(5'd7, 32'hDEAD_BEEF);
    b0.raddr1 = 5'd7; b0.raddr2 = 5'd7;
    #1;
    chk("same_rd1", b0.rdata1, 32'hDEAD_BEEF);
    chk("same_rd2", b0.rdata2, 32'hDEAD_BEEF);
    b0.we = 1'b1; b0.waddr = 5'd7; b0.wdata = 32'hCAFE_F00D;
    #1;
    chk("same_byp_rd1", b0.rdata1, 32'hCAFE_F00D);
    chk("same_byp_rd2", b0.rdata2, 32'hCAFE_F00D);
    @(posedge clk); #1;
    b0.we = 1'b0;
    chk("same_after_rd1", b0.rdata1, 32'hCAFE_F00D);

    // Registered output on d2: one cycle of latency, and a hold while re is low.
    wr8(3'd3, 8'h3C);
    wr8(3'd4, 8'h4D);
    b2.re1 = 1'b1; b2.raddr1 = 3'd3;
    #1;
    chk("oreg_before_edge", {24'h0, b2.rdata1}, 32'h0);
    @(posedge clk); #1;
    chk("oreg_capture", {24'h0, b2.rdata1}, 32'h3C);
    b2.re1 = 1'b0; b2.raddr1 = 3'd4;
    @(posedge clk); #1;
    chk("oreg_hold", {24'h0, b2.rdata1}, 32'h3C);
    // A write and a read of the same address at one edge capture the new data.
    b2.re2 = 1'b1; b2.raddr2 = 3'd6;
    b2.we = 1'b1; b2.waddr = 3'd6; b2.wdata = 8'h77;
    @(posedge clk); #1;
    b2.we = 1'b0; b2.re2 = 1'b0;
    chk("oreg_bypass", {24'h0, b2.rdata2}, 32'h77);
    // Reset clears the output registers without a clock edge.
    @(negedge clk); #1;
    reset = 1'b1;
    #1;
    chk("oreg_rst_rd1", {24'h0, b2.rdata1}, 32'h0);
    chk("oreg_rst_rd2", {24'h0, b2.rdata2}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
